serial_subtract: RTL

//  Bit-serial n-bit subtractor: D = Xin - Yin - borrowin (mod 2^n), plus borrowout.

---
 rtl/serial_subtract.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/serial_subtract.sv
// serial_subtract
//   Bit-serial n-bit subtractor: D = Xin - Yin - borrowin (mod 2^n) plus borrowout.
//   One full-subtractor cell handles one bit per clock, LSB first. Operands are
//   captured on an accepted start. A one-cycle done pulse marks a fresh result.
//
// Parameters
//   n          operand/result width in bits (n >= 2)
//
// Ports
//   Clock      in   sole clock, rising edge
//   Resetn     in   synchronous active-low reset
//   start      in   request, sampled only in IDLE
//   borrowin   in   borrow into bit 0, captured with the operands
//   Xin        in   [n] minuend
//   Yin        in   [n] subtrahend
//   D          out  [n] difference, holds the last completed result
//   borrowout  out  borrow out of bit n-1
//   busy       out  high while the bit loop runs
//   done       out  one-cycle pulse when D/borrowout have just updated
//   ovf        out  signed overflow of the last result
//
// Configuration
//   SUB_OVF_EN  defined: ovf is computed on each completion.
//               undefined: ovf is tied to 0 and no overflow logic is built.

module serial_subtract #(
   parameter int unsigned n = 4
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic         start,
   input  logic         borrowin,
   input  logic [n-1:0] Xin,
   input  logic [n-1:0] Yin,
   output logic [n-1:0] D,
   output logic         borrowout,
   output logic         busy,
   output logic         done,
   output logic         ovf
);

   localparam int unsigned      CntW    = $clog2(n) + 1;
   localparam logic [CntW-1:0]  LastBit = CntW'(n - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e          r_state;
   logic [n-1:0]    r_x;
   logic [n-1:0]    r_y;
   logic [n-1:0]    r_res;
   logic            r_b;
   logic [CntW-1:0] r_cnt;
   logic [n-1:0]    r_d;
   logic            r_borrowout;
   logic            r_busy;
   logic            r_done;

   logic            w_xb;
   logic            w_yb;
   logic            w_d;
   logic            w_b;
   logic [n-1:0]    w_res_next;

   // Full-subtractor cell on the current LSBs of the shifting operands.
   assign w_xb       = r_x[0];
   assign w_yb       = r_y[0];
   assign w_d        = w_xb ^ w_yb ^ r_b;
   assign w_b        = (~w_xb & w_yb) | (~(w_xb ^ w_yb) & r_b);
   // Result enters at the MSB end so after n shifts bit 0 sits at position 0.
   assign w_res_next = {w_d, r_res[n-1:1]};

`ifdef SUB_OVF_EN
   logic r_xmsb;
   logic r_ymsb;
   logic r_ovf;
`endif

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_state     <= StIdle;
         r_x         <= '0;
         r_y         <= '0;
         r_res       <= '0;
         r_b         <= 1'b0;
         r_cnt       <= '0;
         r_d         <= '0;
         r_borrowout <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef SUB_OVF_EN
         r_xmsb      <= 1'b0;
         r_ymsb      <= 1'b0;
         r_ovf       <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (start) begin
                  r_x     <= Xin;
                  r_y     <= Yin;
                  r_b     <= borrowin;
                  r_res   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= StRun;
`ifdef SUB_OVF_EN
                  // Operand MSBs are shifted away during RUN, so keep copies.
                  r_xmsb  <= Xin[n-1];
                  r_ymsb  <= Yin[n-1];
`endif
               end
            end

            StRun: begin
               r_x   <= r_x >> 1;
               r_y   <= r_y >> 1;
               r_b   <= w_b;
               r_res <= w_res_next;
               r_cnt <= r_cnt + CntW'(1);
               if (r_cnt == LastBit) begin
                  r_d         <= w_res_next;
                  r_borrowout <= w_b;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= StDone;
`ifdef SUB_OVF_EN
                  // w_d is the result MSB on this edge.
                  r_ovf       <= (r_xmsb != r_ymsb) & (w_d != r_xmsb);
`endif
               end
            end

            StDone: begin
               r_state <= StIdle;
            end

            default: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign D         = r_d;
   assign borrowout = r_borrowout;
   assign busy      = r_busy;
   assign done      = r_done;

`ifdef SUB_OVF_EN
   assign ovf = r_ovf;
`else
   assign ovf = 1'b0;
`endif

endmodule
